// File: rtl/lmsm_seq_pkg.sv
// Shared definitions for the load/store-multiple sequencer.
// Holds the FSM state type, the parameter defaults and the register-index width.
package lmsm_seq_pkg;

  localparam int unsigned DwDefault   = 16;
  localparam int unsigned NregDefault = 8;
  localparam int unsigned RegIdxW     = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-set-bit priority encoder, purely combinational.
//   mask_i  : 8-bit request mask
//   idx_o   : index of the lowest set bit (0 when mask_i is empty)
//   valid_o : high when any bit of mask_i is set
module prio_enc8 (
  input  logic [7:0] mask_i,
  output logic [2:0] idx_o,
  output logic       valid_o
);

  always_comb begin
    idx_o   = 3'd0;
    valid_o = |mask_i;
    // Scan downwards so the last hit is the lowest set bit.
    for (int i = 7; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/lmsm_seq.sv
// Load/store-multiple sequencer. Walks the set bits of a register mask in ascending
// order, issuing one memory word transfer per selected register at consecutive
// addresses starting from base_addr_i.
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : request, sampled only when idle, with is_lm_i/imm_mask_i/base_addr_i
//   busy_o, done_o    : sequence in progress / one-cycle completion pulse
//   reg_addr_o        : register index of the current transfer
//   rf_rd_data_i      : register-file read data for reg_addr_o (store multiple)
//   rf_wr_en_o/_data_o: register-file write port (load multiple)
//   mem_addr_o        : word address of the current transfer
//   mem_rd_o/mem_wr_o : memory requests, held until mem_ready_i
//   mem_wdata_o       : store data; mem_rdata_i : load data valid with mem_ready_i
module lmsm_seq
  import lmsm_seq_pkg::*;
#(
  parameter int unsigned DW   = DwDefault,
  parameter int unsigned NREG = NregDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               is_lm_i,
  input  logic [NREG-1:0]    imm_mask_i,
  input  logic [DW-1:0]      base_addr_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [RegIdxW-1:0] reg_addr_o,
  input  logic [DW-1:0]      rf_rd_data_i,
  output logic               rf_wr_en_o,
  output logic [DW-1:0]      rf_wr_data_o,
  output logic [DW-1:0]      mem_addr_o,
  output logic               mem_rd_o,
  output logic               mem_wr_o,
  output logic [DW-1:0]      mem_wdata_o,
  input  logic [DW-1:0]      mem_rdata_i,
  input  logic               mem_ready_i
);

  state_e            state_q, state_d;
  logic              is_lm_q, is_lm_d;
  logic [NREG-1:0]   rem_mask_q, rem_mask_d;
  logic [DW-1:0]     cur_addr_q, cur_addr_d;

  logic [7:0]         enc_mask;
  logic [RegIdxW-1:0] enc_idx;
  logic               enc_valid;
  logic [NREG-1:0]    clr_bit;

  assign enc_mask = 8'(rem_mask_q);
  assign clr_bit  = NREG'(1) << enc_idx;

  prio_enc8 u_prio_enc8 (
    .mask_i  (enc_mask),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      is_lm_q    <= 1'b0;
      rem_mask_q <= '0;
      cur_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      is_lm_q    <= is_lm_d;
      rem_mask_q <= rem_mask_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    is_lm_d      = is_lm_q;
    rem_mask_d   = rem_mask_q;
    cur_addr_d   = cur_addr_q;

    done_o       = 1'b0;
    reg_addr_o   = '0;
    rf_wr_en_o   = 1'b0;
    rf_wr_data_o = '0;
    mem_addr_o   = cur_addr_q;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    mem_wdata_o  = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          is_lm_d    = is_lm_i;
          rem_mask_d = imm_mask_i;
          cur_addr_d = base_addr_i;
          state_d    = (imm_mask_i != '0) ? StXfer : StDone;
        end
      end

      StXfer: begin
        reg_addr_o = enc_idx;
        mem_rd_o   = is_lm_q & enc_valid;
        mem_wr_o   = ~is_lm_q & enc_valid;
        if (is_lm_q) begin
          // Write lands on the same edge the memory completes.
          rf_wr_en_o   = mem_ready_i & enc_valid;
          rf_wr_data_o = mem_rdata_i;
        end else begin
          mem_wdata_o = rf_rd_data_i;
        end
        if (mem_ready_i) begin
          rem_mask_d = rem_mask_q & ~clr_bit;
          cur_addr_d = cur_addr_q + DW'(1);
          if (rem_mask_d == '0) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_lmsm_seq.sv
// Scoreboard bench for lmsm_seq: stimulus pushes expected per-cycle events, a negedge
// monitor pops and compares every cycle that shows a strobe or done.
module tb_lmsm_seq;

  localparam logic [1:0] KRd   = 2'd0;
  localparam logic [1:0] KWr   = 2'd1;
  localparam logic [1:0] KDone = 2'd2;
  localparam logic [1:0] KBad  = 2'd3;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  kind;
    logic [2:0]  ra;
    logic [15:0] ma;
    logic [15:0] wd;
    logic [15:0] md;
    logic        wen;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_lm = 1'b0;
  logic [7:0]  imm_mask = 8'h00;
  logic [15:0] base_addr = 16'h0000;
  logic        busy, done;
  logic [2:0]  reg_addr;
  logic [15:0] rf_rd_data;
  logic        rf_wr_en;
  logic [15:0] rf_wr_data;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready = 1'b1;

  logic [31:0] cyc = 0;
  bit          mon_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  ev_t         q[$];

  lmsm_seq #(
    .DW   (16),
    .NREG (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .is_lm_i      (is_lm),
    .imm_mask_i   (imm_mask),
    .base_addr_i  (base_addr),
    .busy_o       (busy),
    .done_o       (done),
    .reg_addr_o   (reg_addr),
    .rf_rd_data_i (rf_rd_data),
    .rf_wr_en_o   (rf_wr_en),
    .rf_wr_data_o (rf_wr_data),
    .mem_addr_o   (mem_addr),
    .mem_rd_o     (mem_rd),
    .mem_wr_o     (mem_wr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ready_i  (mem_ready)
  );

  // Device models: memory word and register contents are fixed functions of address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction
  function automatic logic [15:0] regf(input logic [2:0] r);
    return 16'h1000 + 16'(r) * 16'h0111;
  endfunction

  assign mem_rdata  = memf(mem_addr);
  assign rf_rd_data = regf(reg_addr);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk_ev(input logic [31:0] c, input logic [1:0] k,
                                input logic [2:0] r, input logic [15:0] a, input logic w);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ra   = (k == KDone) ? 3'd0 : r;
    e.ma   = a;
    e.wd   = (k == KRd) ? memf(a) : 16'h0000;
    e.md   = (k == KWr) ? regf(r) : 16'h0000;
    e.wen  = w;
    return e;
  endfunction

  // Pushes the expected events of one sequence. stall: ready-low cycles before the first
  // transfer; nmax >= 0 truncates to that many transfers and drops the done pulse.
  task automatic do_start(input logic lm, input logic [7:0] mask, input logic [15:0] base,
                          input int stall, input int nmax);
    logic [15:0] a;
    logic [31:0] c;
    int n;
    start     = 1'b1;
    is_lm     = lm;
    imm_mask  = mask;
    base_addr = base;
    a = base;
    c = cyc + 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i] && (nmax < 0 || n < nmax)) begin
        if (n == 0) begin
          for (int k = 0; k < stall; k++) begin
            q.push_back(mk_ev(c, lm ? KRd : KWr, 3'(i), a, 1'b0));
            c++;
          end
        end
        q.push_back(mk_ev(c, lm ? KRd : KWr, 3'(i), a, lm));
        a++;
        c++;
        n++;
      end
    end
    if (nmax < 0) q.push_back(mk_ev(c, KDone, 3'd0, a, 1'b0));
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_lm     = 1'b0;
    imm_mask  = 8'h00;
    base_addr = 16'h0000;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d events pending, expected 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: any cycle with a strobe or done must match the next expected event.
  always @(negedge clk) begin
    if (mon_en && (mem_rd || mem_wr || rf_wr_en || done)) begin
      ev_t g, e;
      g.cyc  = cyc;
      g.kind = (mem_rd && !mem_wr && !done) ? KRd :
               (mem_wr && !mem_rd && !done) ? KWr :
               (done && !mem_rd && !mem_wr) ? KDone : KBad;
      g.ra   = reg_addr;
      g.ma   = mem_addr;
      g.wd   = rf_wr_data;
      g.md   = mem_wdata;
      g.wen  = rf_wr_en;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got cyc=%0d kind=%0d ra=%0d ma=%h, expected no event",
                 g.cyc, g.kind, g.ra, g.ma);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display({"FAIL event: got cyc=%0d kind=%0d ra=%0d ma=%h wd=%h md=%h wen=%b, ",
                    "expected cyc=%0d kind=%0d ra=%0d ma=%h wd=%h md=%h wen=%b"},
                   g.cyc, g.kind, g.ra, g.ma, g.wd, g.md, g.wen,
                   e.cyc, e.kind, e.ra, e.ma, e.wd, e.md, e.wen);
        end
      end
    end
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobes", {29'd0, mem_rd, mem_wr, rf_wr_en}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // LM, mask 1010_0101 from 0x0100: R0,R2,R5,R7 at 0100..0103, done 5 cycles after start.
    mem_ready = 1'b1;
    do_start(1'b1, 8'b1010_0101, 16'h0100, 0, -1);
    chk("lm_busy", 32'(busy), 32'd1);
    drain();

    // SM, mask 0x81 from 0xFFFF: address wraps to 0x0000 for R7.
    do_start(1'b0, 8'h81, 16'hFFFF, 0, -1);
    drain();

    // Empty mask: done one cycle after start, busy for exactly that cycle.
    do_start(1'b0, 8'h00, 16'h0777, 0, -1);
    chk("empty_busy_done_cycle", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("empty_busy_after", 32'(busy), 32'd0);
    drain();

    // Stall: LM R1, ready low three cycles, then one write.
    mem_ready = 1'b0;
    do_start(1'b1, 8'h02, 16'h0200, 3, -1);
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    drain();

    // Abort: reset during the second XFER cycle of a full-mask LM.
    do_start(1'b1, 8'hFF, 16'h0300, 0, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_strobes", {29'd0, mem_rd, mem_wr, rf_wr_en}, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    drain();

    // Sequence accepted after abort.
    do_start(1'b0, 8'h06, 16'h0400, 0, -1);
    drain();

    // Start while busy with a different request is ignored.
    do_start(1'b1, 8'h03, 16'h0500, 0, -1);
    start     = 1'b1;
    is_lm     = 1'b0;
    imm_mask  = 8'hFF;
    base_addr = 16'h0900;
    @(posedge clk);
    #1;
    start     = 1'b0;
    imm_mask  = 8'h00;
    base_addr = 16'h0000;
    drain();
    chk("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lmsm_seq.md
LMSM_SEQ -- requirements
Module: lmsm_seq

Interface
REQ-001 Parameter: DW, default 16, the data and address width.
REQ-002 Parameter: NREG, default 8, the number of architectural registers; mask width equals NREG.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin a load/store-multiple; sampled only in IDLE.
REQ-006 is_lm  in  1  1 = load multiple (mem->regs), 0 = store multiple (regs->mem); sampled with start.
REQ-007 imm_mask  in  NREG  register select mask, bit i selects register Ri; sampled with start.
REQ-008 base_addr  in  DW  starting memory word address (value of RA); sampled with start.
REQ-009 busy  out  1  high from the cycle after an accepted start until DONE is left.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 reg_addr  out  3  register index of current transfer; drives register-file read port (SM) or write address (LM).
REQ-012 rf_rd_data  in  DW  register-file read data for reg_addr (combinational).
REQ-013 rf_wr_en  out  1  register-file write strobe (LM only).
REQ-014 rf_wr_data  out  DW  register-file write data.
REQ-015 mem_addr  out  DW  memory word address of current transfer.
REQ-016 mem_rd  out  1  memory read request (LM).
REQ-017 mem_wr  out  1  memory write request (SM).
REQ-018 mem_wdata  out  DW  memory write data.
REQ-019 mem_rdata  in  DW  memory read data, valid when mem_ready is high.
REQ-020 mem_ready  in  1  memory completes the current request this cycle.

Function
REQ-021 FSM states: IDLE, XFER, DONE.
REQ-022 IDLE + start: the block shall latch is_lm, imm_mask into rem_mask, and base_addr into cur_addr, then go to XFER if imm_mask != 0, otherwise to DONE.
REQ-023 start in XFER or DONE shall be ignored, with no latching.
REQ-024 XFER: reg_addr shall equal the index of the lowest set bit of rem_mask, so registers are processed in ascending order.
REQ-025 XFER: mem_addr shall equal cur_addr; mem_rd = is_lm; mem_wr = ~is_lm; requests held high every cycle until mem_ready.
REQ-026 SM: mem_wdata = rf_rd_data combinationally while in XFER.
REQ-027 LM: rf_wr_en = mem_ready while in XFER; rf_wr_data = mem_rdata, so the write lands on the same clk edge.
REQ-028 XFER + mem_ready: the block shall clear the current bit in rem_mask and set cur_addr <= cur_addr + 1 (mod 2^DW, so 16'hFFFF wraps to 16'h0000).
REQ-029 XFER + mem_ready with the cleared rem_mask == 0 shall go to DONE; otherwise remain in XFER.
REQ-030 XFER without mem_ready: all outputs and state shall be held (stall).
REQ-031 DONE: done = 1 for exactly one cycle, then go to IDLE; the next start is accepted in the following IDLE cycle.
REQ-032 Outside XFER: mem_rd = mem_wr = rf_wr_en = 0; reg_addr = 0; mem_addr = cur_addr; data outputs = 0.
REQ-033 busy = (state != IDLE).
REQ-034 Latency: N set bits with mem_ready always high takes N XFER cycles + 1 DONE cycle after the start cycle; an empty mask gives done 1 cycle after start.
REQ-035 Selecting R7 in LM is legal; the write goes through rf_wr_en/reg_addr=7 like any other register, and arbitration against PC update is upstream policy.

Reset
REQ-036 rst shall force IDLE, rem_mask = 0, cur_addr = 0, latched is_lm = 0, and all outputs low/zero in the following cycle.
REQ-037 rst mid-XFER shall abort: no further strobes, no done pulse; a partially completed transfer is not rolled back.
REQ-038 rst has priority over start and mem_ready in the same cycle.

Structure
REQ-039 The shared package shall hold the state enum {IDLE, XFER, DONE}, the DW/NREG defaults, and the 3-bit register-index width.
REQ-040 The lowest-set-bit search shall be a sub-module prio_enc8 (8-bit mask in; 3-bit index and valid out; purely combinational).
REQ-041 No other sub-modules.

Verification
REQ-042 LM: mask 8'b1010_0101, base 16'h0100, mem_ready=1 -> reg_addr 0,2,5,7 at mem_addr 0100..0103 on four consecutive cycles; rf_wr_en high on each; done on the 5th cycle after start.
REQ-043 SM: mask 8'h81, base 16'hFFFF -> mem_wr at FFFF with R0 data, then at 0000 with R7 data (wrap); done follows.
REQ-044 Empty mask: start with mask 8'h00 -> no mem/rf strobes; done exactly one cycle after start; busy high one cycle.
REQ-045 Stall: LM mask 8'h02, mem_ready low 3 cycles then high -> mem_rd held 4 cycles at a constant address; a single rf_wr_en pulse with reg_addr=1.
REQ-046 Abort: rst asserted during the 2nd XFER cycle of mask 8'hFF -> IDLE next cycle, strobes low, no done; a new start is accepted afterwards.
REQ-047 Ignored start: start pulsed while busy with different mask/base -> the current sequence is unchanged.
